// File: rtl/coin_acceptor.sv
// Two-channel coin sensor front end: synchronize, debounce, and arbitrate into
// non-overlapping one-cycle money pulses. Optional running total under COIN_TOTAL_EN.
module coin_debounce #(
    parameter logic [19:0] CNT_MAX = 20'd999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key,
    output logic press
);
    logic [1:0]  sync_ff;
    logic [19:0] cnt;
    logic        key_s;

    assign key_s = sync_ff[1];

    // Synchronizer resets to released (high) so a key held through reset counts from 0.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_ff <= 2'b11;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], key};
            press   <= !key_s && (cnt == CNT_MAX - 20'd1);
            if (key_s)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 20'd1;
        end
    end
endmodule

module coin_acceptor #(
    parameter logic [19:0] CNT_MAX = 20'd999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_one,
    input  logic       key_half,
`ifdef COIN_TOTAL_EN
    output logic [7:0] po_coin_total,
`endif
    output logic       po_money_one,
    output logic       po_money_half
);
    localparam logic [1:0] IDLE      = 2'b01;
    localparam logic [1:0] HALF_PEND = 2'b10;

    logic [1:0] keys;
    logic [1:0] evt;
    logic [1:0] state, state_nx;
    logic       one_pend, pend_nx;
    logic       one_nx, half_nx, one_req;

    assign keys = {key_half, key_one};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        coin_debounce #(.CNT_MAX(CNT_MAX)) u_deb (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .key       (keys[ch]),
            .press     (evt[ch])
        );
    end

    assign one_req = evt[0] | one_pend;

    always_comb begin
        state_nx = state;
        pend_nx  = one_pend;
        one_nx   = 1'b0;
        half_nx  = 1'b0;
        case (state)
            IDLE: begin
                pend_nx = 1'b0;
                if (one_req) begin
                    one_nx = 1'b1;
                    if (evt[1]) state_nx = HALF_PEND;
                end else if (evt[1]) begin
                    half_nx = 1'b1;
                end
            end
            HALF_PEND: begin
                // Half goes out now; a colliding one is deferred, a colliding half is lost.
                half_nx  = 1'b1;
                pend_nx  = evt[0];
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                pend_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= IDLE;
            one_pend      <= 1'b0;
            po_money_one  <= 1'b0;
            po_money_half <= 1'b0;
        end else begin
            state         <= state_nx;
            one_pend      <= pend_nx;
            po_money_one  <= one_nx;
            po_money_half <= half_nx;
        end
    end

`ifdef COIN_TOTAL_EN
    logic [8:0] sum;
    assign sum = {1'b0, po_coin_total} + {7'd0, one_nx, half_nx};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            po_coin_total <= '0;
        else
            po_coin_total <= sum[8] ? 8'hff : sum[7:0];
    end
`endif
endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter CNT_MAX, default 20'd999_999, debounce hold time in sys_clk cycles (20 ms at 50 MHz); legal range 4..2^20-1.
REQ-002 sys_clk  input  1  single clock; all flops on its rising edge.
REQ-003 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-004 key_one  input  1  raw one-unit coin sensor, active-low, asynchronous to sys_clk, may bounce.
REQ-005 key_half  input  1  raw half-unit coin sensor, active-low, asynchronous to sys_clk, may bounce.
REQ-006 po_money_one  output  1  registered one-cycle pulse, one accepted one-unit coin; feeds the vending FSM's pi_money_one.
REQ-007 po_money_half  output  1  registered one-cycle pulse, one accepted half-unit coin; feeds the vending FSM's pi_money_half.
REQ-008 po_coin_total  output  8  running inserted value in half-units; present only under COIN_TOTAL_EN.

Function
REQ-009 Each key SHALL pass through a dedicated two-flop synchronizer before any other use.
REQ-010 Each channel SHALL have a 20-bit debounce counter: cleared to 0 while its synchronized key is high, incremented while low, saturating at CNT_MAX.
REQ-011 A channel press event SHALL be registered high for exactly one cycle on the edge where its counter goes CNT_MAX-1 -> CNT_MAX; a held key yields exactly one event per press.
REQ-012 A low glitch shorter than CNT_MAX synchronized cycles SHALL produce no event; any synchronized high sample restarts the count from 0.
REQ-013 Output arbiter states: IDLE, HALF_PEND (one-hot, 2 bits).
REQ-014 IDLE: one event only -> po_money_one=1; half event only -> po_money_half=1; both same cycle -> po_money_one=1 and go to HALF_PEND.
REQ-015 HALF_PEND: po_money_half=1 for one cycle, return to IDLE; a one event arriving in this cycle is held as pending and issued next cycle (swap roles); a half event arriving in this cycle is dropped.
REQ-016 po_money_one and po_money_half SHALL never be high in the same cycle.
REQ-017 Latency: a clean press SHALL produce its output pulse at edge CNT_MAX+3, counting the first edge sampling the key low as edge 1.
REQ-018 Outputs SHALL be low in every cycle without a pulse; no pulse is lost except the case in REQ-015.

Reset
REQ-019 sys_rst_n low SHALL immediately set: synchronizer flops to 1 (released), counters to 0, events to 0, arbiter to IDLE, po_money_one=0, po_money_half=0, po_coin_total=0.
REQ-020 Reset asserted mid-count or with a pending half SHALL discard all progress; after release a key still held low SHALL be counted from 0 and produce one pulse at the REQ-017 latency.

Configuration
REQ-021 Macro COIN_TOTAL_EN: when defined, port po_coin_total exists and SHALL add 2 per po_money_one pulse and 1 per po_money_half pulse, updated on the pulse edge, saturating at 255.
REQ-022 Without COIN_TOTAL_EN the port and its counter SHALL be absent; all other behaviour is identical.

Verification (CNT_MAX=4)
REQ-023 key_one low from edge 1, held 50 cycles -> po_money_one high exactly during the cycle after edge 7, no further pulse.
REQ-024 key_half bouncing low 3 cycles / high 1 cycle, repeated 5 times, then high -> no pulse on either output.
REQ-025 key_one and key_half driven low on the same edge -> po_money_one pulse after edge 7, po_money_half pulse after edge 8, never simultaneous.
REQ-026 key_one low, sys_rst_n pulsed low at edge 5, key held -> no pulse before reset, one pulse 7 edges after first post-release sample.
REQ-027 With COIN_TOTAL_EN: presses one, half, one -> po_coin_total 2, 3, 5; 130 one-unit presses -> po_coin_total holds 255.
